// File: rtl/ram_byte_wr_packer_if.sv
// Byte-stream input and RAM write-port output bundle for ram_byte_wr_packer.
// The slave modport is the packer; the master modport is whoever feeds it.
interface ram_byte_wr_packer_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    localparam int LANES = DATA_W / 8;

    logic              i_start;
    logic [ADDR_W-1:0] i_base_addr;
    logic              i_stall;
    logic [7:0]        i_in_data;
    logic              i_in_valid;
    logic              i_in_last;
    logic              o_in_ready;
    logic [ADDR_W-1:0] o_wa;
    logic [DATA_W-1:0] o_wd;
    logic [LANES-1:0]  o_wen;
    logic              o_wclk_en;
    logic              o_done;
    logic              o_busy;
    logic              o_wrapped;
    logic [ADDR_W:0]   o_words;

    modport slave (
        input  i_start, i_base_addr, i_stall, i_in_data, i_in_valid, i_in_last,
        output o_in_ready, o_wa, o_wd, o_wen, o_wclk_en, o_done, o_busy,
               o_wrapped, o_words
    );

    modport master (
        output i_start, i_base_addr, i_stall, i_in_data, i_in_valid, i_in_last,
        input  o_in_ready, o_wa, o_wd, o_wen, o_wclk_en, o_done, o_busy,
               o_wrapped, o_words
    );
endinterface

// File: rtl/ram_byte_wr_packer.sv
// Packs a valid/ready byte stream into little-endian RAM words and issues
// byte-enabled writes at an auto-incrementing, wrapping word address.
module ram_byte_wr_packer #(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 2 ** ADDR_W,
    parameter int DATA_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    ram_byte_wr_packer_if.slave   bus
);
    localparam int LANES  = DATA_W / 8;
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;

    logic [ADDR_W-1:0]  r_addr;
    logic [LANE_W-1:0]  r_lane;
    logic [LANES-1:0]   r_mask;
    logic [DATA_W-1:0]  r_asmWord;

    logic [ADDR_W-1:0]  r_wa;
    logic [DATA_W-1:0]  r_wd;
    logic [LANES-1:0]   r_wen;
    logic               r_wclkEn;
    logic               r_done;
    logic               r_wrapped;
    logic [ADDR_W:0]    r_words;

    logic               w_inReady;
    logic               w_accept;
    logic               w_wordDone;
    logic               w_atTop;
    logic [DATA_W-1:0]  w_wordNext;
    logic [LANES-1:0]   w_maskNext;

    // Start always wins over a byte offered in the same cycle.
    assign w_inReady  = (r_state == FILL) & ~bus.i_start & ~bus.i_stall;
    assign w_accept   = w_inReady & bus.i_in_valid;
    assign w_wordDone = w_accept & ((r_lane == LANE_W'(LANES - 1)) | bus.i_in_last);
    assign w_atTop    = (r_addr == ADDR_W'(DEPTH - 1));

    always_comb begin
        w_wordNext = r_asmWord;
        w_maskNext = r_mask;
        w_wordNext[{r_lane, 3'b000} +: 8] = bus.i_in_data;
        w_maskNext[r_lane] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (bus.i_start) begin
                    w_stateNext = FILL;
                end
            end
            FILL: begin
                if (bus.i_start) begin
                    w_stateNext = FILL;
                end else if (w_accept && bus.i_in_last) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Strobe, enables and Done are one-cycle pulses; WA/WD keep their last value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr    <= '0;
            r_lane    <= '0;
            r_mask    <= '0;
            r_asmWord <= '0;
            r_wa      <= '0;
            r_wd      <= '0;
            r_wen     <= '0;
            r_wclkEn  <= 1'b0;
            r_done    <= 1'b0;
            r_wrapped <= 1'b0;
            r_words   <= '0;
        end else begin
            r_wclkEn <= 1'b0;
            r_wen    <= '0;
            r_done   <= 1'b0;
            if (bus.i_start) begin
                r_addr    <= bus.i_base_addr;
                r_lane    <= '0;
                r_mask    <= '0;
                r_asmWord <= '0;
                r_wrapped <= 1'b0;
                r_words   <= '0;
            end else if (w_wordDone) begin
                r_wclkEn  <= 1'b1;
                r_wa      <= r_addr;
                r_wd      <= w_wordNext;
                r_wen     <= w_maskNext;
                r_done    <= bus.i_in_last;
                r_addr    <= w_atTop ? '0 : r_addr + ADDR_W'(1);
                r_lane    <= '0;
                r_mask    <= '0;
                r_asmWord <= '0;
                if (w_atTop) begin
                    r_wrapped <= 1'b1;
                end
                if (r_words != (ADDR_W + 1)'(DEPTH)) begin
                    r_words <= r_words + (ADDR_W + 1)'(1);
                end
            end else if (w_accept) begin
                r_lane    <= r_lane + LANE_W'(1);
                r_mask    <= w_maskNext;
                r_asmWord <= w_wordNext;
            end
        end
    end

    assign bus.o_in_ready = w_inReady;
    assign bus.o_wa       = r_wa;
    assign bus.o_wd       = r_wd;
    assign bus.o_wen      = r_wen;
    assign bus.o_wclk_en  = r_wclkEn;
    assign bus.o_done     = r_done;
    assign bus.o_busy     = (r_state == FILL);
    assign bus.o_wrapped  = r_wrapped;
    assign bus.o_words    = r_words;
endmodule

// File: tb/tb_ram_byte_wr_packer.sv
// Directed scenario bench for ram_byte_wr_packer; every write strobe is logged
// as {WA, WD, WEN, Done, Wrapped, Words} and compared to hand-computed words.
module tb_ram_byte_wr_packer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_byte_wr_packer_if #(.ADDR_W(9), .DATA_W(32)) bus ();

    ram_byte_wr_packer #(.ADDR_W(9), .DEPTH(512), .DATA_W(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    bit timedOut;
    logic [56:0] strobes[$];

    always @(negedge clk) begin
        if (bus.o_wclk_en === 1'b1) begin
            strobes.push_back({bus.o_wa, bus.o_wd, bus.o_wen, bus.o_done, bus.o_wrapped, bus.o_words});
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [8:0] base);
        bus.i_start     = 1'b1;
        bus.i_base_addr = base;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit last);
        int n;
        n = 0;
        bus.i_in_valid = 1'b1;
        bus.i_in_data  = d;
        bus.i_in_last  = last;
        @(negedge clk);
        while (bus.o_in_ready !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (n >= 20) timedOut = 1'b1;
        @(posedge clk);
        #1;
        bus.i_in_valid = 1'b0;
        bus.i_in_last  = 1'b0;
    endtask

    task automatic test_reset();
        logic [59:0] act;
        @(negedge clk);
        act = {bus.o_in_ready, bus.o_busy, bus.o_wclk_en, bus.o_wen, bus.o_done,
               bus.o_wrapped, bus.o_words, bus.o_wa, bus.o_wd};
        total++;
        if (act !== 60'h0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: actual=%h required=0", act);
        end
        idle(1);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.o_in_ready !== 1'b0 || bus.o_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_not_ready: actual ready=%b busy=%b required 0/0",
                     bus.o_in_ready, bus.o_busy);
        end
        idle(1);
    endtask

    task automatic test_full_words();
        logic [56:0] exp[2];
        strobes.delete();
        timedOut = 1'b0;
        do_start(9'd0);
        for (int i = 0; i < 8; i++) send_byte(8'(17 * (i + 1)), i == 7);
        idle(2);
        exp[0] = {9'd0, 32'h44332211, 4'hF, 1'b0, 1'b0, 10'd1};
        exp[1] = {9'd1, 32'h88776655, 4'hF, 1'b1, 1'b0, 10'd2};
        total++;
        if (timedOut !== 1'b0 || strobes.size() != 2) begin
            bad++;
            $display("[TB] FAIL full_count: actual=%0d timeout=%b required=2", strobes.size(), timedOut);
        end
        for (int k = 0; k < 2 && k < strobes.size(); k++) begin
            total++;
            if (strobes[k] !== exp[k]) begin
                bad++;
                $display("[TB] FAIL full_strobe%0d: actual=%h required=%h", k, strobes[k], exp[k]);
            end
        end
        total++;
        if (bus.o_busy !== 1'b0 || bus.o_words !== 10'd2 || bus.o_wrapped !== 1'b0) begin
            bad++;
            $display("[TB] FAIL full_after: actual busy=%b words=%0d wrapped=%b required 0/2/0",
                     bus.o_busy, bus.o_words, bus.o_wrapped);
        end
    endtask

    task automatic test_partial();
        logic [56:0] exp[2];
        strobes.delete();
        timedOut = 1'b0;
        do_start(9'd5);
        for (int i = 0; i < 6; i++) send_byte(8'(17 * (i + 1)), i == 5);
        idle(2);
        exp[0] = {9'd5, 32'h44332211, 4'hF, 1'b0, 1'b0, 10'd1};
        exp[1] = {9'd6, 32'h00006655, 4'h3, 1'b1, 1'b0, 10'd2};
        total++;
        if (timedOut !== 1'b0 || strobes.size() != 2) begin
            bad++;
            $display("[TB] FAIL partial_count: actual=%0d timeout=%b required=2", strobes.size(), timedOut);
        end
        for (int k = 0; k < 2 && k < strobes.size(); k++) begin
            total++;
            if (strobes[k] !== exp[k]) begin
                bad++;
                $display("[TB] FAIL partial_strobe%0d: actual=%h required=%h", k, strobes[k], exp[k]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [56:0] exp[3];
        strobes.delete();
        timedOut = 1'b0;
        do_start(9'd510);
        for (int i = 0; i < 12; i++) send_byte(8'(i + 1), i == 11);
        idle(2);
        exp[0] = {9'd510, 32'h04030201, 4'hF, 1'b0, 1'b0, 10'd1};
        exp[1] = {9'd511, 32'h08070605, 4'hF, 1'b0, 1'b1, 10'd2};
        exp[2] = {9'd0,   32'h0C0B0A09, 4'hF, 1'b1, 1'b1, 10'd3};
        total++;
        if (timedOut !== 1'b0 || strobes.size() != 3) begin
            bad++;
            $display("[TB] FAIL wrap_count: actual=%0d timeout=%b required=3", strobes.size(), timedOut);
        end
        for (int k = 0; k < 3 && k < strobes.size(); k++) begin
            total++;
            if (strobes[k] !== exp[k]) begin
                bad++;
                $display("[TB] FAIL wrap_strobe%0d: actual=%h required=%h", k, strobes[k], exp[k]);
            end
        end
    endtask

    task automatic test_stall();
        logic [56:0] exp;
        strobes.delete();
        timedOut = 1'b0;
        do_start(9'd20);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        bus.i_stall    = 1'b1;
        bus.i_in_valid = 1'b1;
        bus.i_in_data  = 8'h33;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (bus.o_in_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL stall_ready%0d: actual=%b required=0", i, bus.o_in_ready);
            end
            @(posedge clk);
            #1;
        end
        bus.i_stall = 1'b0;
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        idle(2);
        exp = {9'd20, 32'h44332211, 4'hF, 1'b1, 1'b0, 10'd1};
        total++;
        if (timedOut !== 1'b0 || strobes.size() != 1) begin
            bad++;
            $display("[TB] FAIL stall_count: actual=%0d timeout=%b required=1", strobes.size(), timedOut);
        end
        if (strobes.size() > 0) begin
            total++;
            if (strobes[0] !== exp) begin
                bad++;
                $display("[TB] FAIL stall_strobe: actual=%h required=%h", strobes[0], exp);
            end
        end
    endtask

    task automatic test_restart();
        logic [56:0] exp[2];
        strobes.delete();
        timedOut = 1'b0;
        do_start(9'd511);
        for (int i = 0; i < 4; i++) send_byte(8'(i + 1), 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        do_start(9'd100);
        @(negedge clk);
        total++;
        if (bus.o_wrapped !== 1'b0 || bus.o_words !== 10'd0 || bus.o_busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL restart_clear: actual wrapped=%b words=%0d busy=%b required 0/0/1",
                     bus.o_wrapped, bus.o_words, bus.o_busy);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send_byte(8'(i + 1), i == 3);
        idle(2);
        exp[0] = {9'd511, 32'h04030201, 4'hF, 1'b0, 1'b1, 10'd1};
        exp[1] = {9'd100, 32'h04030201, 4'hF, 1'b1, 1'b0, 10'd1};
        total++;
        if (timedOut !== 1'b0 || strobes.size() != 2) begin
            bad++;
            $display("[TB] FAIL restart_count: actual=%0d timeout=%b required=2", strobes.size(), timedOut);
        end
        for (int k = 0; k < 2 && k < strobes.size(); k++) begin
            total++;
            if (strobes[k] !== exp[k]) begin
                bad++;
                $display("[TB] FAIL restart_strobe%0d: actual=%h required=%h", k, strobes[k], exp[k]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [59:0] act;
        strobes.delete();
        timedOut = 1'b0;
        do_start(9'd7);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        bus.i_in_valid = 1'b1;
        bus.i_in_data  = 8'h33;
        rst_n = 1'b0;
        @(negedge clk);
        act = {bus.o_in_ready, bus.o_busy, bus.o_wclk_en, bus.o_wen, bus.o_done,
               bus.o_wrapped, bus.o_words, bus.o_wa, bus.o_wd};
        total++;
        if (act !== 60'h0) begin
            bad++;
            $display("[TB] FAIL midreset_outputs: actual=%h required=0", act);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (bus.o_in_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL midreset_ready%0d: actual=%b required=0", i, bus.o_in_ready);
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (strobes.size() != 0) begin
            bad++;
            $display("[TB] FAIL midreset_nostrobe: actual=%0d required=0", strobes.size());
        end
        bus.i_in_valid = 1'b0;
        do_start(9'd0);
        @(negedge clk);
        total++;
        if (bus.o_in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midreset_restart_ready: actual=%b required=1", bus.o_in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.i_start     = 1'b0;
        bus.i_base_addr = '0;
        bus.i_stall     = 1'b0;
        bus.i_in_data   = '0;
        bus.i_in_valid  = 1'b0;
        bus.i_in_last   = 1'b0;
        idle(2);
        test_reset();
        test_full_words();
        test_partial();
        test_wrap();
        test_stall();
        test_restart();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
